uart_mem_loader: RTL

//  Receive end of the serial line: boot loader that takes a framed byte stream on rx and

---
 rtl/uart_mem_loader.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mem_loader.sv
// UART boot loader: receives a framed 8N1 byte stream on rx and writes each
// 32-bit little-endian word into the four byte-lane banks of imem or dmem.
// Holds the core (busy) while a frame is being accepted.
module uart_mem_loader #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned ADDR_W       = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              CEN_imem  [0:3],
    output logic              GWEN_imem [0:3],
    output logic [7:0]        WEN_imem  [0:3],
    output logic [ADDR_W-1:0] A_imem    [0:3],
    output logic [7:0]        D_imem    [0:3],
    output logic              CEN_dmem  [0:3],
    output logic              GWEN_dmem [0:3],
    output logic [7:0]        WEN_dmem  [0:3],
    output logic [ADDR_W-1:0] A_dmem    [0:3],
    output logic [7:0]        D_dmem    [0:3]
);

    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]   MAX_LEN   = 17'(1) << ADDR_W;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [3:0] {
        S_IDLE, S_TGT, S_AL, S_AH, S_LL, S_LH, S_DATA, S_WRITE, S_CSUM
    } state_e;

    // receiver state
    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e     rs_q, rs_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          byte_vld, frm_err;

    // frame state
    state_e            st_q, st_d;
    logic              sel_q, sel_d;          // 1 = dmem
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        lane_q [0:2];
    logic [7:0]        lane_d [0:2];
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    // registered SRAM pins (cen_* is active-low and also drives GWEN/WEN)
    logic              cen_i_q, cen_i_d, cen_m_q, cen_m_d;
    logic [ADDR_W-1:0] a_i_q, a_i_d, a_m_q, a_m_d;
    logic [7:0]        d_i_q [0:3];
    logic [7:0]        d_i_d [0:3];
    logic [7:0]        d_m_q [0:3];
    logic [7:0]        d_m_d [0:3];

    // 2-flop synchroniser plus one more stage for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // receiver state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_q   <= R_IDLE;
            bcnt_q <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
        end else begin
            rs_q   <= rs_d;
            bcnt_q <= bcnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
        end
    end

    // receiver next state: start-bit recheck at half bit, then bit-centre sampling
    always_comb begin
        rs_d     = rs_q;
        bcnt_d   = bcnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        byte_vld = 1'b0;
        frm_err  = 1'b0;
        case (rs_q)
            R_IDLE: begin
                bcnt_d = '0;
                if (rx_s3_q && !rx_s2_q) rs_d = R_START;
            end
            R_START: begin
                if (bcnt_q == HALF_LAST) begin
                    bcnt_d = '0;
                    bit_d  = '0;
                    rs_d   = rx_s2_q ? R_IDLE : R_DATA;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d = '0;
                    sh_d   = {rx_s2_q, sh_q[7:1]};
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'd7) rs_d = R_STOP;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d = '0;
                    rs_d   = R_IDLE;
                    if (rx_s2_q) byte_vld = 1'b1;
                    else         frm_err  = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: rs_d = R_IDLE;
        endcase
    end

    // frame FSM and SRAM pin registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= S_IDLE;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            lane_q  <= '{default: '0};
            idx_q   <= '0;
            csum_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cen_i_q <= 1'b1;
            cen_m_q <= 1'b1;
            a_i_q   <= '0;
            a_m_q   <= '0;
            d_i_q   <= '{default: '0};
            d_m_q   <= '{default: '0};
        end else begin
            st_q    <= st_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            lane_q  <= lane_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cen_i_q <= cen_i_d;
            cen_m_q <= cen_m_d;
            a_i_q   <= a_i_d;
            a_m_q   <= a_m_d;
            d_i_q   <= d_i_d;
            d_m_q   <= d_m_d;
        end
    end

    // frame FSM next state; the write is set up on the 4th byte so the
    // SRAM pins are active exactly during the WRITE cycle
    always_comb begin
        st_d    = st_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        len_d   = len_q;
        lane_d  = lane_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cen_i_d = 1'b1;
        cen_m_d = 1'b1;
        a_i_d   = '0;
        a_m_d   = '0;
        d_i_d   = '{default: '0};
        d_m_d   = '{default: '0};
        if (frm_err) begin
            st_d   = S_IDLE;
            busy_d = 1'b0;
            err_d  = 1'b1;
        end else begin
            case (st_q)
                S_IDLE: if (byte_vld && sh_q == 8'hA5) begin
                    st_d   = S_TGT;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                end
                S_TGT: if (byte_vld) begin
                    if (sh_q == 8'h00 || sh_q == 8'h01) begin
                        sel_d = sh_q[0];
                        st_d  = S_AL;
                    end else begin
                        st_d   = S_IDLE;
                        busy_d = 1'b0;
                        err_d  = 1'b1;
                    end
                end
                S_AL: if (byte_vld) begin
                    addr_d = ADDR_W'(sh_q);
                    st_d   = S_AH;
                end
                S_AH: if (byte_vld) begin
                    addr_d = ADDR_W'({sh_q, 8'(addr_q)});
                    st_d   = S_LL;
                end
                S_LL: if (byte_vld) begin
                    len_d = {8'h00, sh_q};
                    st_d  = S_LH;
                end
                S_LH: if (byte_vld) begin
                    if ({sh_q, len_q[7:0]} == 16'h0000 ||
                        {1'b0, sh_q, len_q[7:0]} > MAX_LEN) begin
                        st_d   = S_IDLE;
                        busy_d = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        len_d  = {sh_q, len_q[7:0]};
                        idx_d  = '0;
                        csum_d = '0;
                        st_d   = S_DATA;
                    end
                end
                S_DATA: if (byte_vld) begin
                    csum_d = csum_q + sh_q;
                    if (idx_q == 2'd3) begin
                        idx_d = '0;
                        st_d  = S_WRITE;
                        if (sel_q) begin
                            cen_m_d = 1'b0;
                            a_m_d   = addr_q;
                            d_m_d   = '{lane_q[0], lane_q[1], lane_q[2], sh_q};
                        end else begin
                            cen_i_d = 1'b0;
                            a_i_d   = addr_q;
                            d_i_d   = '{lane_q[0], lane_q[1], lane_q[2], sh_q};
                        end
                    end else begin
                        lane_d[idx_q] = sh_q;
                        idx_d         = idx_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    addr_d = addr_q + 1'b1;
                    len_d  = len_q - 1'b1;
                    st_d   = (len_q == 16'd1) ? S_CSUM : S_DATA;
                end
                S_CSUM: if (byte_vld) begin
                    st_d   = S_IDLE;
                    busy_d = 1'b0;
                    if (sh_q == csum_q) done_d = 1'b1;
                    else                err_d  = 1'b1;
                end
                default: begin
                    st_d   = S_IDLE;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // fan the registered write controls out to all four banks
    always_comb begin
        busy = busy_q;
        done = done_q;
        err  = err_q;
        for (int unsigned k = 0; k < 4; k++) begin
            CEN_imem[k]  = cen_i_q;
            GWEN_imem[k] = cen_i_q;
            WEN_imem[k]  = {8{cen_i_q}};
            A_imem[k]    = a_i_q;
            D_imem[k]    = d_i_q[k];
            CEN_dmem[k]  = cen_m_q;
            GWEN_dmem[k] = cen_m_q;
            WEN_dmem[k]  = {8{cen_m_q}};
            A_dmem[k]    = a_m_q;
            D_dmem[k]    = d_m_q[k];
        end
    end

endmodule
